// File: rtl/serdes_rx_pkg.sv
// Shared types and constants for the SERDES receive deframer.
package serdes_rx_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_TRAILER  = 3'd3,
        ST_DISCARD  = 3'd4
    } state_e;

    localparam int          K_FLAG_BIT    = 1;
    localparam logic [7:0]  SR_ENABLE_OFF = 8'd0;
    localparam logic [7:0]  SR_MAXLEN_OFF = 8'd1;
    localparam logic [7:0]  SR_CLEAR_OFF  = 8'd2;
    localparam logic [15:0] ABORT_TAG     = 16'hDEAD;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/serdes_rx_setting_reg.sv
// Settings-bus register: loads the low WIDTH bits of set_data on an address match.
module serdes_rx_setting_reg #(
    parameter logic [7:0]       ADDR    = 8'd0,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      in,
    output logic [WIDTH-1:0] out,
    output logic             wr
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             unused_in;

    assign wr        = strobe && (addr == ADDR);
    assign out       = out_q;
    assign unused_in = ^in;

    always_comb begin
        out_d = out_q;
        if (wr) out_d = in[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= RST_VAL;
        else     out_q <= out_d;
    end

endmodule

// File: rtl/serdes_rx_deframer.sv
// Packet deframer for the SERDES receive word stream (K-word strip, length/checksum check).
// Define SEQ_CHECK_EN to add header sequence-number checking.
module serdes_rx_deframer
    import serdes_rx_pkg::*;
#(
    parameter logic [7:0]  SR_BASE     = 8'd132,
    parameter logic [15:0] DEF_MAX_LEN = 16'd512
) (
    input  logic        dsp_clk,
    input  logic        dsp_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_flags,
    input  logic        rx_pop_rdy,
    output logic        rx_pop_en,
    output logic [31:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] good_count,
    output logic [15:0] err_count,
    output logic [31:0] debug
);

    logic        enable;
    logic [15:0] max_len;
    logic        clear;
    logic        clear_val;
    logic        unused_ok;

    serdes_rx_setting_reg #(.ADDR(SR_BASE + SR_ENABLE_OFF), .WIDTH(1), .RST_VAL(1'b0)) u_enable (
        .clk(dsp_clk), .rst(dsp_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(enable), .wr()
    );

    serdes_rx_setting_reg #(.ADDR(SR_BASE + SR_MAXLEN_OFF), .WIDTH(16), .RST_VAL(DEF_MAX_LEN)) u_max_len (
        .clk(dsp_clk), .rst(dsp_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(max_len), .wr()
    );

    serdes_rx_setting_reg #(.ADDR(SR_BASE + SR_CLEAR_OFF), .WIDTH(1), .RST_VAL(1'b0)) u_clear (
        .clk(dsp_clk), .rst(dsp_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(clear_val), .wr(clear)
    );

    state_e      state_q, state_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic        out_err_q, out_err_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] csum_q, csum_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] hdr_q, hdr_d;
    logic [15:0] good_q, good_d;
    logic [15:0] err_q, err_d;
    logic        hit_q, hit_d;
    logic        pop;
    logic        is_k;
    logic        bad;
    logic        good_inc;
    logic        err_inc;
`ifdef SEQ_CHECK_EN
    logic [15:0] exp_seq_q, exp_seq_d;
    logic        exp_valid_q, exp_valid_d;
    logic        seq_bad_q, seq_bad_d;
`endif

    assign is_k      = rx_flags[K_FLAG_BIT];
    assign unused_ok = ^{rx_flags[3:2], rx_flags[0], clear_val};

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q && !out_ready;
        csum_d      = csum_q;
        rem_d       = rem_q;
        hdr_d       = hdr_q;
        good_d      = good_q;
        err_d       = err_q;
        hit_d       = hit_q;
        bad         = 1'b0;
        good_inc    = 1'b0;
        err_inc     = 1'b0;
`ifdef SEQ_CHECK_EN
        exp_seq_d   = exp_seq_q;
        exp_valid_d = exp_valid_q;
        seq_bad_d   = seq_bad_q;
`endif

        // Disabled discards freely; otherwise pop only when the output slot frees up.
        if (dsp_rst)
            pop = 1'b0;
        else if (state_q == ST_DISABLED)
            pop = rx_pop_rdy;
        else if (state_q == ST_IDLE && !enable)
            pop = 1'b0;
        else
            pop = rx_pop_rdy && (!out_valid_q || out_ready);

        unique case (state_q)
            ST_DISABLED: begin
                if (enable) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!enable) begin
                    state_d = ST_DISABLED;
                end else if (pop && !is_k) begin
                    if (rx_data[15:0] != 16'd0 && rx_data[15:0] <= max_len) begin
                        out_valid_d = 1'b1;
                        out_sop_d   = 1'b1;
                        out_eop_d   = 1'b0;
                        out_err_d   = 1'b0;
                        out_data_d  = rx_data;
                        csum_d      = rx_data;
                        hdr_d       = rx_data;
                        rem_d       = rx_data[15:0];
                        state_d     = ST_PAYLOAD;
`ifdef SEQ_CHECK_EN
                        seq_bad_d   = exp_valid_q && (rx_data[31:16] != exp_seq_q);
`endif
                    end else begin
                        hit_d   = 1'b1;
                        err_inc = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_PAYLOAD, ST_TRAILER: begin
                if (pop) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b0;
                    if (is_k) begin
                        out_eop_d  = 1'b1;
                        out_err_d  = 1'b1;
                        out_data_d = {ABORT_TAG, rem_q};
                        err_inc    = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (state_q == ST_PAYLOAD) begin
                        out_eop_d  = 1'b0;
                        out_err_d  = 1'b0;
                        out_data_d = rx_data;
                        csum_d     = csum_q + rx_data;
                        rem_d      = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = ST_TRAILER;
                    end else begin
                        bad = (rx_data != csum_q);
`ifdef SEQ_CHECK_EN
                        bad = bad || seq_bad_q;
                        if (!bad || seq_bad_q) begin
                            exp_seq_d   = hdr_q[31:16] + 16'd1;
                            exp_valid_d = 1'b1;
                        end
`endif
                        out_eop_d  = 1'b1;
                        out_err_d  = bad;
                        out_data_d = hdr_q;
                        good_inc   = !bad;
                        err_inc    = bad;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (pop && is_k) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear write wins over any increment in the same cycle.
        if (clear) begin
            good_d = 16'd0;
            err_d  = 16'd0;
            hit_d  = 1'b0;
`ifdef SEQ_CHECK_EN
            exp_valid_d = 1'b0;
`endif
        end else begin
            if (good_inc) good_d = sat_inc(good_q);
            if (err_inc)  err_d  = sat_inc(err_q);
        end
    end

    always_ff @(posedge dsp_clk) begin
        if (dsp_rst) begin
            state_q     <= ST_IDLE;
            out_data_q  <= 32'd0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            csum_q      <= 32'd0;
            rem_q       <= 16'd0;
            hdr_q       <= 32'd0;
            good_q      <= 16'd0;
            err_q       <= 16'd0;
            hit_q       <= 1'b0;
`ifdef SEQ_CHECK_EN
            exp_seq_q   <= 16'd0;
            exp_valid_q <= 1'b0;
            seq_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            csum_q      <= csum_d;
            rem_q       <= rem_d;
            hdr_q       <= hdr_d;
            good_q      <= good_d;
            err_q       <= err_d;
            hit_q       <= hit_d;
`ifdef SEQ_CHECK_EN
            exp_seq_q   <= exp_seq_d;
            exp_valid_q <= exp_valid_d;
            seq_bad_q   <= seq_bad_d;
`endif
        end
    end

    assign rx_pop_en  = pop;
    assign out_data   = out_data_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;
    assign good_count = good_q;
    assign err_count  = err_q;
    assign debug      = {err_q[7:0], good_q[7:0], 8'b0, enable, hit_q, 3'b0, state_q};

endmodule

// File: tb/tb_serdes_rx_deframer.sv
// Directed self-checking bench for serdes_rx_deframer.
module tb_serdes_rx_deframer;

    logic        dsp_clk = 1'b0;
    logic        dsp_rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] rx_data = 32'd0;
    logic [3:0]  rx_flags = 4'd0;
    logic        rx_pop_rdy = 1'b0;
    logic        rx_pop_en;
    logic [31:0] out_data;
    logic        out_sop, out_eop, out_err, out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] good_count, err_count;
    logic [31:0] debug;

    int n_chk  = 0;
    int n_pass = 0;
    logic [34:0] beats[$];

    serdes_rx_deframer dut (
        .dsp_clk(dsp_clk), .dsp_rst(dsp_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rx_data(rx_data), .rx_flags(rx_flags), .rx_pop_rdy(rx_pop_rdy),
        .rx_pop_en(rx_pop_en),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .good_count(good_count), .err_count(err_count), .debug(debug)
    );

    always #5 dsp_clk = ~dsp_clk;

    always @(negedge dsp_clk)
        if (!dsp_rst && out_valid && out_ready)
            beats.push_back({out_sop, out_eop, out_err, out_data});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge dsp_clk);
        #1;
    endtask

    task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge dsp_clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic k);
        logic popped;
        popped = 1'b0;
        rx_data = d; rx_flags = k ? 4'b0010 : 4'b0000; rx_pop_rdy = 1'b1;
        for (int i = 0; i < 50 && !popped; i++) begin
            @(negedge dsp_clk);
            if (rx_pop_en) begin
                @(posedge dsp_clk); #1;
                popped = 1'b1;
            end
        end
        rx_pop_rdy = 1'b0;
        chk("pop_timeout", 64'(popped), 64'd1);
    endtask

    task automatic exp_beat(input string tag, input logic s, input logic e,
                            input logic r, input logic [31:0] d);
        logic [34:0] b;
        b = 'x;
        if (beats.size() != 0) b = beats.pop_front();
        chk(tag, 64'(b), 64'({s, e, r, d}));
    endtask

    initial begin
        int stuck;
        int moved;

        // reset: pop must stay low even with a word waiting
        rx_pop_rdy = 1'b1;
        cycles(2);
        @(negedge dsp_clk);
        chk("rst_pop_en", 64'(rx_pop_en), 64'd0);
        chk("rst_valid", 64'({out_valid, out_sop, out_eop, out_err}), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_debug", 64'(debug), 64'h0000_0001);
        rx_pop_rdy = 1'b0;
        @(posedge dsp_clk); #1;
        dsp_rst = 1'b0;

        sr_write(8'd132, 32'd1);
        cycles(3);
        chk("en_debug", 64'(debug), 64'h0000_0081);

        // A: good packet
        push(32'h0001_0003, 0); push(32'd1, 0); push(32'd2, 0); push(32'd3, 0);
        push(32'h0001_0009, 0);
        cycles(3);
        exp_beat("A_sop", 1, 0, 0, 32'h0001_0003);
        exp_beat("A_d1", 0, 0, 0, 32'd1);
        exp_beat("A_d2", 0, 0, 0, 32'd2);
        exp_beat("A_d3", 0, 0, 0, 32'd3);
        exp_beat("A_eop", 0, 1, 0, 32'h0001_0003);
        chk("A_cnt", 64'({good_count, err_count}), 64'h0001_0000);

        // B: checksum error
        push(32'h0002_0003, 0); push(32'd1, 0); push(32'd2, 0); push(32'd3, 0);
        push(32'h0000_0000, 0);
        cycles(3);
        exp_beat("B_sop", 1, 0, 0, 32'h0002_0003);
        exp_beat("B_d1", 0, 0, 0, 32'd1);
        exp_beat("B_d2", 0, 0, 0, 32'd2);
        exp_beat("B_d3", 0, 0, 0, 32'd3);
        exp_beat("B_eop", 0, 1, 1, 32'h0002_0003);
        chk("B_cnt", 64'({good_count, err_count}), 64'h0001_0001);

        // C: K word mid-payload, then D accepted normally
        push(32'h0002_0003, 0); push(32'd1, 0); push(32'd2, 0);
        push(32'hBCBC_BCBC, 1);
        push(32'h0002_0001, 0); push(32'd5, 0); push(32'h0002_0006, 0);
        cycles(3);
        exp_beat("C_sop", 1, 0, 0, 32'h0002_0003);
        exp_beat("C_d1", 0, 0, 0, 32'd1);
        exp_beat("C_d2", 0, 0, 0, 32'd2);
        exp_beat("C_abort", 0, 1, 1, 32'hDEAD_0001);
        exp_beat("D_sop", 1, 0, 0, 32'h0002_0001);
        exp_beat("D_d1", 0, 0, 0, 32'd5);
        exp_beat("D_eop", 0, 1, 0, 32'h0002_0001);
        chk("D_cnt", 64'({good_count, err_count}), 64'h0002_0002);

        // E: oversize header is discarded up to the next K word
        sr_write(8'd133, 32'd4);
        push(32'h0009_0005, 0);
        for (int i = 0; i < 6; i++) push(32'h100 + 32'(i), 0);
        push(32'hBCBC_BCBC, 1);
        cycles(3);
        chk("E_nobeats", 64'(beats.size()), 64'd0);
        chk("E_debug", 64'(debug), 64'h0302_00C1);

        // F: valid packet after discard
        push(32'h0003_0002, 0); push(32'd7, 0); push(32'd8, 0);
        push(32'h0003_0011, 0);
        cycles(3);
        exp_beat("F_sop", 1, 0, 0, 32'h0003_0002);
        exp_beat("F_d1", 0, 0, 0, 32'd7);
        exp_beat("F_d2", 0, 0, 0, 32'd8);
        exp_beat("F_eop", 0, 1, 0, 32'h0003_0002);
        chk("F_cnt", 64'({good_count, err_count}), 64'h0003_0003);

        // G: consumer stall mid-payload
        push(32'h0004_0002, 0); push(32'h11, 0);
        out_ready = 1'b0;
        rx_data = 32'h22; rx_flags = 4'd0; rx_pop_rdy = 1'b1;
        stuck = 0; moved = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge dsp_clk);
            if (rx_pop_en) stuck++;
            if (!out_valid || out_data != 32'h11 || out_sop || out_eop) moved++;
        end
        chk("G_stall_pop", 64'(stuck), 64'd0);
        chk("G_stall_hold", 64'(moved), 64'd0);
        @(posedge dsp_clk); #1;
        out_ready = 1'b1;
        push(32'h22, 0); push(32'h0004_0035, 0);
        cycles(3);
        exp_beat("G_sop", 1, 0, 0, 32'h0004_0002);
        exp_beat("G_d1", 0, 0, 0, 32'h11);
        exp_beat("G_d2", 0, 0, 0, 32'h22);
        exp_beat("G_eop", 0, 1, 0, 32'h0004_0002);
        chk("G_nodup", 64'(beats.size()), 64'd0);
        chk("G_cnt", 64'({good_count, err_count}), 64'h0004_0003);

        // H: clear in the same cycle as a good trailer
        push(32'h0005_0001, 0); push(32'd9, 0);
        rx_data = 32'h0005_000A; rx_flags = 4'd0; rx_pop_rdy = 1'b1;
        set_stb = 1'b1; set_addr = 8'd134; set_data = 32'd0;
        @(negedge dsp_clk);
        chk("H_pop", 64'(rx_pop_en), 64'd1);
        @(posedge dsp_clk); #1;
        rx_pop_rdy = 1'b0; set_stb = 1'b0;
        cycles(3);
        exp_beat("H_sop", 1, 0, 0, 32'h0005_0001);
        exp_beat("H_d1", 0, 0, 0, 32'd9);
        exp_beat("H_eop", 0, 1, 0, 32'h0005_0001);
        chk("H_cnt", 64'({good_count, err_count}), 64'h0000_0000);
        chk("H_debug", 64'(debug), 64'h0000_0081);

        // I/J: seq 5 then 7
        push(32'h0005_0001, 0); push(32'd1, 0); push(32'h0005_0002, 0);
        push(32'h0007_0001, 0); push(32'd1, 0); push(32'h0007_0002, 0);
        cycles(3);
        exp_beat("I_sop", 1, 0, 0, 32'h0005_0001);
        exp_beat("I_d1", 0, 0, 0, 32'd1);
        exp_beat("I_eop", 0, 1, 0, 32'h0005_0001);
        exp_beat("J_sop", 1, 0, 0, 32'h0007_0001);
        exp_beat("J_d1", 0, 0, 0, 32'd1);
`ifdef SEQ_CHECK_EN
        exp_beat("J_eop", 0, 1, 1, 32'h0007_0001);
        chk("J_cnt", 64'({good_count, err_count}), 64'h0001_0001);
`else
        exp_beat("J_eop", 0, 1, 0, 32'h0007_0001);
        chk("J_cnt", 64'({good_count, err_count}), 64'h0002_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serdes_rx_deframer.md
Name: serdes_rx_deframer

Overview:
- Consumes the 32-bit word stream popped from the SERDES receive CDC FIFO pair on dsp_clk.
- Strips K-character idle/filler words, delimits packets, checks length and checksum, and presents payload as a registered valid/ready stream to the DSP-side consumer.
- Configured over the settings bus; keeps good/error packet counts.

Parameters:
- SR_BASE, 8'd132: settings-bus base address; registers at SR_BASE+0..+2.
- DEF_MAX_LEN, 16'd512: reset value of the maximum payload length, in words.

Ports:
- dsp_clk  in  1  sole clock.
- dsp_rst  in  1  reset, synchronous and active-high.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- rx_data  in  32  upstream word.
- rx_flags  in  4  bit1=1: K word (both halves control); other bits ignored.
- rx_pop_rdy  in  1  upstream word available.
- rx_pop_en  out  1  pop upstream word this cycle.
- out_data  out  32  output beat.
- out_sop  out  1  header beat.
- out_eop  out  1  trailer/status beat.
- out_err  out  1  valid only with out_eop: packet bad.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- good_count  out  16  saturating count of good packets.
- err_count  out  16  saturating count of bad packets.
- debug  out  32  {err_count[7:0], good_count[7:0], 8'b0, enable, max_len_hit, 3'b0, state[2:0]}.

Behaviour:
- Settings registers:
  - SR_BASE+0 bit0 = enable, reset 0.
  - SR_BASE+1 [15:0] = max_len, reset DEF_MAX_LEN.
  - SR_BASE+2: any write clears both counters; clear beats a same-cycle increment.
- Reset: out_valid/out_sop/out_eop/out_err=0, out_data=0, counters=0, state=IDLE, rx_pop_en=0 in the reset cycle.
- Pop rule:
  - DISABLED: rx_pop_en = rx_pop_rdy; words are discarded.
  - Otherwise: rx_pop_en = rx_pop_rdy && (!out_valid || out_ready).
  - A popped word that produces a beat is registered: out_valid rises the cycle after the pop (1-cycle latency).
  - out_* must hold stable while out_valid && !out_ready.
- Packet format:
  - Header: [31:16] seq, [15:0] len.
  - Then len payload words.
  - Then a trailer holding the checksum: 32-bit mod-2^32 sum of the header and all payload words.
- States: DISABLED, IDLE, PAYLOAD, TRAILER, DISCARD.
- DISABLED: goes to IDLE when enable=1. Enable is sampled only in IDLE/DISABLED, so clearing it mid-packet lets the packet complete, then the state goes to DISABLED.
- IDLE:
  - K word: dropped, no beat.
  - Non-K word: header.
    - If 1<=len<=max_len: emit out_sop beat with data=header, set checksum=header, load remaining=len, go to PAYLOAD.
    - Else (len=0 or len>max_len): set max_len_hit, err_count++, no beat, go to DISCARD.
- PAYLOAD:
  - Non-K word: emit a data beat, add it to the checksum, decrement remaining; remaining reaching 0 goes to TRAILER.
  - K word: abort. Emit beat out_eop=1, out_err=1, data=32'hDEAD_0000|remaining; err_count++; go to IDLE.
- TRAILER:
  - Non-K word: emit out_eop beat, data={seq,len}, out_err=(word!=checksum); bump good_count or err_count accordingly; go to IDLE.
  - K word: same abort as PAYLOAD.
- DISCARD: drop every non-K word; the first K word goes to IDLE.
- Counters saturate at 16'hFFFF. max_len_hit clears when SR_BASE+2 is written.

Optional Feature:
- SEQ_CHECK_EN: defined adds a 16-bit expected-sequence register.
  - Expected value loads from the first good packet after reset or counter clear, then +1 (wrapping 16'hFFFF->0) after each good packet.
  - A header seq mismatch sets out_err on that packet's eop beat and counts as error; expected then resyncs to received seq+1.
- Undefined: seq is passed through unchecked; no register is built.

Decomposition:
- Package serdes_rx_pkg: state enum, K-flag bit index (1), SR offsets (0, 1, 2), abort tag 16'hDEAD.
- One sub-module, serdes_rx_setting_reg: address-match register with reset value, one instance per register.

Test Plan:
- Enable, then header 32'h0001_0003, payload 1, 2, 3, trailer 32'h0001_0009 -> beats sop(00010003), 1, 2, 3, eop(00010003) with err=0; good_count=1.
- Same packet with trailer 32'h0000_0000 -> eop with err=1; err_count=1, good_count unchanged.
- K word after 2 of 3 payload words -> eop beat data=32'hDEAD0001, err=1; the next header is accepted normally.
- max_len=4, header len=5, followed by 6 words then a K word -> no beats, err_count=1, max_len_hit=1; the next valid packet passes.
- Hold out_ready=0 for 5 cycles mid-payload -> rx_pop_en=0 after the register fills; beat held stable; no loss or duplication once released.
- Counter-clear write in the same cycle as a good trailer -> good_count=0. With SEQ_CHECK_EN, seq 5 then 7 -> second packet err=1.
